// File: rtl/sys_defs.sv
// Shared CDB arbiter parameters and bus payload types.
package sys_defs;

  localparam int unsigned NUM_FU   = 8;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // One functional unit's completed-result request toward the CDB.
  typedef struct packed {
    logic             done;
    logic [TAG_W-1:0] rob_tag;
    logic [XLEN-1:0]  result;
  } fu_req_t;

  // One broadcast on the Common Data Bus.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rob_tag;
    logic [XLEN-1:0]  value;
  } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned N = 8,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      j = IDX_W'((32'(ptr) + off) % N);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/cdb_arb.sv
// Common Data Bus arbiter: round-robin select among completed FUs,
// combinational ack, registered broadcast one cycle later.
module cdb_arb
  import sys_defs::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_FU-1:0]       fu_done,
  input  logic [NUM_FU*XLEN-1:0]  fu_result,
  input  logic [NUM_FU*TAG_W-1:0] fu_rob_tag,
  output logic [NUM_FU-1:0]       ack,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_rob_tag,
  output logic [XLEN-1:0]         cdb_value,
  output logic [NUM_FU-1:0]       dones_dbg,
  output logic [NUM_FU-1:0]       ack_dbg
);

  fu_req_t              reqs [NUM_FU];
  logic [NUM_FU-1:0]    req_vec;
  logic [NUM_FU-1:0]    grant;
  logic [FU_IDX_W-1:0]  gnt_idx;
  logic                 gnt_valid;
  logic [FU_IDX_W-1:0]  rr;
  cdb_t                 cdb_q;

  // Unpack the flat FU buses into per-FU request structs.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_unpack
    assign reqs[i].done    = fu_done[i];
    assign reqs[i].rob_tag = fu_rob_tag[i*TAG_W +: TAG_W];
    assign reqs[i].result  = fu_result[i*XLEN +: XLEN];
  end

  always_comb begin
    req_vec = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      req_vec[i] = reqs[i].done;
    end
  end

  rr_arbiter #(.N(NUM_FU)) u_rr_arbiter (
    .req   (req_vec),
    .ptr   (rr),
    .grant (grant),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  // Broadcast register and round-robin pointer; payload holds when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_q <= '0;
      rr    <= '0;
    end else if (gnt_valid) begin
      cdb_q.valid   <= 1'b1;
      cdb_q.rob_tag <= reqs[gnt_idx].rob_tag;
      cdb_q.value   <= reqs[gnt_idx].result;
      rr            <= (gnt_idx == FU_IDX_W'(NUM_FU - 1)) ? '0
                                                          : gnt_idx + FU_IDX_W'(1);
    end else begin
      cdb_q.valid <= 1'b0;
    end
  end

  // No grant may escape while the core is held in reset.
  assign ack         = reset ? grant : '0;
  assign cdb_valid   = cdb_q.valid;
  assign cdb_rob_tag = cdb_q.rob_tag;
  assign cdb_value   = cdb_q.value;
  assign dones_dbg   = fu_done;
  assign ack_dbg     = ack;

endmodule

// File: tb/tb_cdb_arb.sv
// Directed and random scoreboard bench for the CDB arbiter.
module tb_cdb_arb;
  import sys_defs::*;

  logic                    clock;
  logic                    reset;
  logic [NUM_FU-1:0]       fu_done;
  logic [NUM_FU*XLEN-1:0]  fu_result;
  logic [NUM_FU*TAG_W-1:0] fu_rob_tag;
  logic [NUM_FU-1:0]       ack;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_rob_tag;
  logic [XLEN-1:0]         cdb_value;
  logic [NUM_FU-1:0]       dones_dbg;
  logic [NUM_FU-1:0]       ack_dbg;

  cdb_arb dut (
    .clock       (clock),
    .reset       (reset),
    .fu_done     (fu_done),
    .fu_result   (fu_result),
    .fu_rob_tag  (fu_rob_tag),
    .ack         (ack),
    .cdb_valid   (cdb_valid),
    .cdb_rob_tag (cdb_rob_tag),
    .cdb_value   (cdb_value),
    .dones_dbg   (dones_dbg),
    .ack_dbg     (ack_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive_fu(input int i, input logic d, input logic [TAG_W-1:0] t,
                          input logic [XLEN-1:0] v);
    fu_done[i]                   = d;
    fu_rob_tag[i*TAG_W +: TAG_W] = t;
    fu_result[i*XLEN +: XLEN]    = v;
  endtask

  task automatic expect_bcast(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Pop one expected broadcast, or require an idle bus if none is owed.
  task automatic check_cdb(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_valid"}, 64'(cdb_valid), 64'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_valid"}, 64'(cdb_valid), 64'd1);
      chk({name, "_tag"}, 64'(cdb_rob_tag), 64'(e.tag));
      chk({name, "_value"}, 64'(cdb_value), 64'(e.val));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit                pend [NUM_FU];
    logic [TAG_W-1:0]  ptag [NUM_FU];
    logic [XLEN-1:0]   pval [NUM_FU];
    logic [NUM_FU-1:0] exp_ack;
    int                m_rr;
    int                issued;
    int                bcast;
    int                cycles;
    bit                any_pend;

    reset      = 1'b0;
    fu_done    = '0;
    fu_result  = '0;
    fu_rob_tag = '0;
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, 1'b1, TAG_W'(i), XLEN'(100 + i));

    // Reset hold with every FU requesting.
    cyc();
    cyc();
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_tag", 64'(cdb_rob_tag), 64'd0);
    chk("rst_value", 64'(cdb_value), 64'd0);
    chk("rst_ack", 64'(ack), 64'h00);
    chk("rst_dones_dbg", 64'(dones_dbg), 64'hFF);
    reset = 1'b1;
    #1;
    chk("rel_ack", 64'(ack), 64'h01);
    chk("rel_ack_dbg", 64'(ack_dbg), 64'h01);
    fu_done = '0;
    #1;
    chk("idle_ack", 64'(ack), 64'h00);

    // Contention from rr=0: FU1 then FU2.
    drive_fu(1, 1'b1, 5'd3, 32'd250);
    drive_fu(2, 1'b1, 5'd4, 32'd7);
    #1;
    chk("cont_ack0", 64'(ack), 64'h02);
    expect_bcast(5'd3, 32'd250);
    cyc();
    check_cdb("cont0");
    fu_done[1] = 1'b0;
    #1;
    chk("cont_ack1", 64'(ack), 64'h04);
    expect_bcast(5'd4, 32'd7);
    cyc();
    check_cdb("cont1");
    fu_done[2] = 1'b0;
    cyc();
    check_cdb("cont_idle");

    // Single request from rr=3 wraps around to FU1.
    drive_fu(1, 1'b1, 5'd2, 32'd6);
    #1;
    chk("single_ack", 64'(ack), 64'h02);
    expect_bcast(5'd2, 32'd6);
    cyc();
    check_cdb("single");
    fu_done[1] = 1'b0;
    cyc();
    check_cdb("single_drop");
    chk("hold_tag", 64'(cdb_rob_tag), 64'd2);
    chk("hold_value", 64'(cdb_value), 64'd6);

    // Grant FU7, then FU0 alone, then all: rr must sit at 0.
    drive_fu(7, 1'b1, 5'd7, 32'd107);
    #1;
    chk("wrap7_ack", 64'(ack), 64'h80);
    expect_bcast(5'd7, 32'd107);
    cyc();
    check_cdb("wrap7");
    fu_done[7] = 1'b0;
    drive_fu(0, 1'b1, 5'd0, 32'd100);
    #1;
    chk("wrap0_ack", 64'(ack), 64'h01);
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, 1'b1, TAG_W'(i), XLEN'(100 + i));
    #1;
    chk("wrap_rr0_ack", 64'(ack), 64'h01);

    // Fairness: all FUs held done for two full rotations.
    for (int k = 0; k < 16; k++) begin
      chk("rot_ack", 64'(ack), 64'(8'h01 << (k % 8)));
      expect_bcast(TAG_W'(k % 8), XLEN'(100 + k % 8));
      cyc();
      check_cdb("rot");
    end
    fu_done = '0;

    // rr = 7 with only FU0 requesting.
    fu_done = 8'h40;
    #1;
    chk("pre7_ack", 64'(ack), 64'h40);
    expect_bcast(5'd6, 32'd106);
    cyc();
    check_cdb("pre7");
    fu_done = 8'h01;
    #1;
    chk("from7_ack", 64'(ack), 64'h01);
    expect_bcast(5'd0, 32'd100);
    cyc();
    check_cdb("from7");
    fu_done = '0;

    // Asynchronous reset while a broadcast is on the bus.
    fu_done = 8'h08;
    #1;
    chk("prerst_ack", 64'(ack), 64'h08);
    expect_bcast(5'd3, 32'd103);
    cyc();
    check_cdb("prerst");
    reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(cdb_valid), 64'd0);
    chk("midrst_tag", 64'(cdb_rob_tag), 64'd0);
    chk("midrst_value", 64'(cdb_value), 64'd0);
    chk("midrst_ack", 64'(ack), 64'h00);
    cyc();
    reset   = 1'b1;
    fu_done = 8'h0A;
    #1;
    chk("postrst_ack0", 64'(ack), 64'h02);
    expect_bcast(5'd1, 32'd101);
    cyc();
    check_cdb("postrst0");
    fu_done = 8'h08;
    #1;
    chk("postrst_ack1", 64'(ack), 64'h08);
    expect_bcast(5'd3, 32'd103);
    cyc();
    check_cdb("postrst1");
    fu_done = '0;
    cyc();
    check_cdb("postrst_idle");

    // Random stress: 30 requests, each held until acknowledged.
    m_rr   = 4;
    issued = 0;
    bcast  = 0;
    cycles = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      pend[i] = 1'b0;
      ptag[i] = '0;
      pval[i] = '0;
    end
    any_pend = 1'b0;
    while ((issued < 30 || any_pend) && cycles < 2000) begin
      int g;
      for (int i = 0; i < NUM_FU; i++) begin
        if (!pend[i] && issued < 30 && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          ptag[i] = TAG_W'($urandom);
          pval[i] = $urandom;
          issued++;
        end
      end
      for (int i = 0; i < NUM_FU; i++) drive_fu(i, pend[i], ptag[i], pval[i]);
      #1;
      exp_ack = '0;
      g = -1;
      for (int off = 0; off < NUM_FU; off++) begin
        int j;
        j = (m_rr + off) % NUM_FU;
        if (g < 0 && pend[j]) g = j;
      end
      if (g >= 0) begin
        exp_ack[g] = 1'b1;
        expect_bcast(ptag[g], pval[g]);
        pend[g] = 1'b0;
        m_rr    = (g + 1) % NUM_FU;
      end
      chk("rnd_ack", 64'(ack), 64'(exp_ack));
      chk("rnd_onehot", 64'($onehot0(ack)), 64'd1);
      cyc();
      check_cdb("rnd");
      if (cdb_valid === 1'b1) bcast++;
      cycles++;
      any_pend = 1'b0;
      for (int i = 0; i < NUM_FU; i++) if (pend[i]) any_pend = 1'b1;
    end
    fu_done = '0;
    chk("rnd_budget", 64'(cycles < 2000), 64'd1);
    chk("rnd_issued", 64'(issued), 64'd30);
    chk("rnd_bcast", 64'(bcast), 64'd30);
    chk("rnd_sb_empty", 64'(sb.size()), 64'd0);
    cyc();
    chk("final_idle", 64'(cdb_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cdb_arb.md
Name: cdb_arb

Overview:
- Common Data Bus arbiter for the out-of-order core.
- Sits between the execute stage's functional units (FUs) and all CDB consumers (RS, ROB, map table).
- Each cycle it selects one FU with a completed result, using round-robin priority, and acknowledges that FU.
- It broadcasts the selected result on a registered CDB output the following cycle.

Parameters:
- NUM_FU, 8, number of functional-unit result ports.
- XLEN, 32, result data width.
- TAG_W, 5, ROB tag width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- fu_done  in  NUM_FU  bit i high = FU i holds a valid completed result.
- fu_result  in  NUM_FU*XLEN  FU i result occupies slice [i*XLEN +: XLEN].
- fu_rob_tag  in  NUM_FU*TAG_W  FU i ROB tag occupies slice [i*TAG_W +: TAG_W].
- ack  out  NUM_FU  one-hot grant; combinational; FU i may retire its result at the next posedge.
- cdb_valid  out  1  registered broadcast valid.
- cdb_rob_tag  out  TAG_W  registered broadcast ROB tag.
- cdb_value  out  XLEN  registered broadcast result.
- dones_dbg  out  NUM_FU  copy of fu_done.
- ack_dbg  out  NUM_FU  copy of ack.

Behaviour:
- Reset (reset==0, asynchronous):
  - cdb_valid, cdb_rob_tag and cdb_value are 0.
  - Round-robin pointer rr is 0.
  - ack is forced to 0 while reset is low.
- Arbitration (combinational):
  - Scan fu_done starting at index rr, wrapping modulo NUM_FU.
  - The first set bit g wins; ack = one-hot(g).
  - If fu_done == 0, ack = 0.
  - ack never has more than one bit set.
- Posedge with a grant:
  - cdb_valid <= 1, cdb_rob_tag <= tag[g], cdb_value <= result[g].
  - rr <= (g+1) mod NUM_FU.
- Posedge with no grant:
  - cdb_valid <= 0; cdb_rob_tag and cdb_value hold their previous values.
  - rr holds.
- Latency: an FU asserting done in cycle N, with no competitors, appears on the CDB from posedge N+1 through posedge N+2.
- Throughput: one broadcast per cycle; back-to-back grants are allowed.
- Handshake:
  - An FU keeps done, result and tag stable until it sees ack high at a posedge.
  - It deasserts done the following cycle unless it has a new result.
  - The arbiter does not latch unacknowledged requests.
- Fairness: with all FUs continuously done, grants rotate 0,1,...,NUM_FU-1,0,...; worst-case wait is NUM_FU-1 cycles.
- Wrap-around: rr == NUM_FU-1 with only FU 0 done grants FU 0 and sets rr to 0.
- Simultaneous events: same-cycle requests are resolved solely by rr order. Tag values have no priority; tag 0 is an ordinary tag.
- Reset mid-operation: outputs clear immediately (asynchronously). Pending FU requests are re-arbitrated from rr=0 after release.
- Debug: dones_dbg = fu_done and ack_dbg = ack, both purely combinational.

Decomposition:
- Shared package (sys_defs) holds:
  - NUM_FU, XLEN, TAG_W.
  - An FU-to-CDB request struct (done, rob_tag, result).
  - A CDB broadcast struct (valid, rob_tag, value), which replaces the flat ports where packetized interfaces are used.
- Sub-module: rr_arbiter (parameterised NUM_FU). Takes req and ptr; outputs a one-hot grant and the encoded index. The top level holds the output registers and the rr pointer.

Test Plan:
- Reset hold:
  - Stimulus: reset=0 for 2 cycles with fu_done=8'hFF.
  - Required: cdb_valid=0, cdb_rob_tag=0, cdb_value=0, ack=0. After release, the first grant is ack=8'h01.
- Single request:
  - Stimulus: FU1 done, tag 2, result 6.
  - Required: ack=8'h02 that cycle. Next posedge: cdb_valid=1, tag 2, value 6. The cycle after with no requests: cdb_valid=0.
- Contention rotation:
  - Stimulus: FU1 (tag 3, value 250) and FU2 (tag 4, value 7) done together, each dropping done after its ack.
  - Required: CDB shows tag 3, then tag 4, on consecutive cycles.
- Round-robin fairness:
  - Stimulus: all 8 FUs held done, with tags equal to index, for 16 cycles.
  - Required: cdb_rob_tag sequence 0..7,0..7 with no repeats before a full rotation.
- Wrap-around:
  - Stimulus: grant FU7, then only FU0 done.
  - Required: ack=8'h01 and rr returns to 0.
- Random stress:
  - Stimulus: 30 random tag/result requests on random FUs, each done held until acked.
  - Required: every request is broadcast exactly once with matching tag and value, and ack is one-hot or zero every cycle.
